bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Parametrised N-channel memory-bus arbiter with request/response handshake.
//  Sits between the pipeline request ports (fetch, load/store, later DMA/debug) and the single external bus.
//  Arbitrates the channels, then performs one bus transaction at a time.
//  Per transaction it generates byte strobes, lane-replicated write data and aligned, sign/zero-extended load data.
//  Adds fixed or round-robin priority, misalignment rejection and a transaction timeout.
// PARAMETERS
//  CHANNELS     2   number of requester channels (1..8); channel 0 = highest fixed priority
//  ROUND_ROBIN  0   0: fixed priority (lowest index wins); 1: round-robin starting after last grant
//  TIMEOUT      0   bus cycles to wait for ext_ready before abort; 0 disables timeout
// PORTS
//  clk              in   1            clock; everything on rising edge
//  reset            in   1            synchronous, active-high reset
//  req_valid        in   CHANNELS     channel c requests; held until req_ready[c]
//  req_instruction  in   CHANNELS     request is an instruction fetch (forwarded to ext_instruction)
//  req_store        in   CHANNELS     1: store, 0: load
//  req_signed       in   CHANNELS     sign-extend load result
//  req_size         in   2*CHANNELS   0: byte, 1: half, 2: word (3 treated as word)
//  req_address      in   32*CHANNELS  byte address
//  req_store_data   in   32*CHANNELS  store data, right-justified
//  req_ready        out  CHANNELS     one-cycle completion pulse for channel c
//  req_error        out  CHANNELS     with req_ready: access rejected (misaligned) or timed out
//  req_load_data    out  32           shifted/extended load data; valid while any req_ready bit is high
//  ext_valid        out  1            bus transaction active
//  ext_instruction  out  1            latched req_instruction of granted channel
//  ext_ready        in   1            bus completes transaction this cycle
//  ext_address      out  32           {address[31:2],2'b00}
//  ext_write_data   out  32           lane-replicated store data
//  ext_write_strobe out  4            byte enables; 4'b0000 for loads
//  ext_read_data    in   32           read word, sampled when ext_valid && ext_ready
// BEHAVIOUR
//  - Reset values: ext_valid=0, req_ready=0, req_error=0, ext_write_strobe=0.
//    All data/address outputs =0; RR pointer=0; FSM=IDLE.
//  - FSM IDLE -> BUS -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant one channel per the priority rule.
//    Latch the granted channel's fields into internal registers.
//    If the access is misaligned (half with addr[0]=1; word with addr[1:0]!=0), go to RESP with error=1 and no bus cycle.
//    Otherwise go to BUS with ext_valid=1 from the next cycle.
//    With no valid request, stay in IDLE.
//  - BUS: ext_* outputs held stable while ext_valid=1.
//    On ext_ready, register the aligned load data and go to RESP.
//    When TIMEOUT>0, a counter starts at 0 on BUS entry and increments each cycle without ext_ready.
//    Reaching TIMEOUT-1 without ext_ready aborts: ext_valid=0 next cycle, go to RESP with error=1.
//    ext_ready wins if it coincides with the final count.
//  - RESP: req_ready[g]=1 for exactly one cycle; req_error[g]=error; go to IDLE.
//    Requester may drop or re-assert req_valid in the RESP cycle.
//    Re-arbitration happens in the following IDLE cycle.
//  - Best-case latency: req_valid seen cycle t -> ext_valid t+1 -> (ext_ready t+1) -> req_ready t+2.
//    Throughput is one transaction per 3 cycles minimum.
//  - Round-robin: after a grant to g, search starts at (g+1) mod CHANNELS.
//    The pointer is updated only on grant.
//  - Strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
//  - Write data: byte replicated x4; half replicated x2; word as-is.
//  - Load data: word >> (8*a[1:0]), then truncated to size and sign- or zero-extended per req_signed.
//  - Reset in any state: the transaction is abandoned and no req_ready pulse is generated.
//    ext_valid=0 in the cycle after reset is sampled.
//  - req_valid dropping while in BUS is a protocol violation; the transaction still completes.
// TESTING
//  - Word load, ch0 addr 0x100, ext_read_data=0xDEADBEEF, ext_ready after 2 cycles:
//    -> ext_address=0x100, strobe=0, req_ready[0] pulse, req_load_data=0xDEADBEEF.
//  - Signed byte load addr 0x103, read 0x80FF_FFFF -> req_load_data=0xFFFFFF80.
//    Same access unsigned -> 0x00000080.
//  - Half store addr 0x202, data 0x1234ABCD -> ext_address=0x200, strobe=4'b1100, ext_write_data=0xABCDABCD.
//  - Both channels valid continuously, ROUND_ROBIN=1 -> grants alternate 0,1,0,1.
//    Same stimulus with ROUND_ROBIN=0 -> channel 0 only.
//  - Word load addr 0x101 -> no ext_valid; req_ready and req_error pulse together 2 cycles after the request.
//  - TIMEOUT=4, ext_ready held 0 -> ext_valid high 4 cycles, then req_ready+req_error pulse.
//    Reset asserted mid-BUS -> ext_valid=0 next cycle, no req_ready pulse.

Source files
------------

// File: rtl/bus_arbiter.sv
// N-channel memory-bus arbiter: picks one requester, runs a single bus transaction,
// then returns a one-cycle completion pulse with aligned load data or an error flag.
module bus_arbiter #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      req_valid,
  input  logic [CHANNELS-1:0]      req_instruction,
  input  logic [CHANNELS-1:0]      req_store,
  input  logic [CHANNELS-1:0]      req_signed,
  input  logic [2*CHANNELS-1:0]    req_size,
  input  logic [32*CHANNELS-1:0]   req_address,
  input  logic [32*CHANNELS-1:0]   req_store_data,
  output logic [CHANNELS-1:0]      req_ready,
  output logic [CHANNELS-1:0]      req_error,
  output logic [31:0]              req_load_data,
  output logic                     ext_valid,
  output logic                     ext_instruction,
  input  logic                     ext_ready,
  output logic [31:0]              ext_address,
  output logic [31:0]              ext_write_data,
  output logic [3:0]               ext_write_strobe,
  input  logic [31:0]              ext_read_data
);

  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ChW-1:0]  gnt_q, gnt_d;
  logic [ChW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            instr_q, instr_d;
  logic            store_q, store_d;
  logic            signed_q, signed_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     load_q, load_d;

  logic           hit_any, hit_hi;
  logic [ChW-1:0] gnt_any, gnt_hi, gnt_sel;
  logic           sel_instr, sel_store, sel_signed, misaligned;
  logic [1:0]     sel_size;
  logic [31:0]    sel_addr, sel_wdata, shifted, aligned;

  // Descending scan so the lowest qualifying index wins; gnt_hi only counts indices at or
  // above the round-robin pointer, falling back to gnt_any to wrap around.
  always_comb begin
    hit_any = 1'b0;
    hit_hi  = 1'b0;
    gnt_any = '0;
    gnt_hi  = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        hit_any = 1'b1;
        gnt_any = ChW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hit_hi = 1'b1;
          gnt_hi = ChW'(i);
        end
      end
    end
    gnt_sel = ((ROUND_ROBIN != 0) && hit_hi) ? gnt_hi : gnt_any;
  end

  always_comb begin
    sel_instr  = 1'b0;
    sel_store  = 1'b0;
    sel_signed = 1'b0;
    sel_size   = 2'd0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (gnt_sel == ChW'(i)) begin
        sel_instr  = req_instruction[i];
        sel_store  = req_store[i];
        sel_signed = req_signed[i];
        sel_size   = req_size[2*i +: 2];
        sel_addr   = req_address[32*i +: 32];
        sel_wdata  = req_store_data[32*i +: 32];
      end
    end
    misaligned = ((sel_size == 2'd1) && sel_addr[0]) ||
                 (sel_size[1] && (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    shifted = ext_read_data >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'd0:    aligned = signed_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      2'd1:    aligned = signed_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    instr_d  = instr_q;
    store_d  = store_q;
    signed_d = signed_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    unique case (state_q)
      StIdle: begin
        if (hit_any) begin
          gnt_d    = gnt_sel;
          rr_ptr_d = (gnt_sel == ChW'(CHANNELS - 1)) ? '0 : gnt_sel + ChW'(1);
          instr_d  = sel_instr;
          store_d  = sel_store;
          signed_d = sel_signed;
          size_d   = sel_size;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          err_d    = misaligned;
          cnt_d    = '0;
          state_d  = misaligned ? StResp : StBus;
        end
      end
      StBus: begin
        // A ready arriving on the final count still completes normally.
        if (ext_ready) begin
          load_d  = aligned;
          state_d = StResp;
        end else if ((TIMEOUT > 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      instr_q  <= 1'b0;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      instr_q  <= instr_d;
      store_q  <= store_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      req_ready[i] = (state_q == StResp) && (gnt_q == ChW'(i));
      req_error[i] = (state_q == StResp) && (gnt_q == ChW'(i)) && err_q;
    end
    req_load_data   = load_q;
    ext_valid       = (state_q == StBus);
    ext_instruction = instr_q;
    ext_address     = {addr_q[31:2], 2'b00};
    unique case (size_q)
      2'd0: begin
        ext_write_strobe = 4'b0001 << addr_q[1:0];
        ext_write_data   = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        ext_write_strobe = 4'b0011 << addr_q[1:0];
        ext_write_data   = {2{wdata_q[15:0]}};
      end
      default: begin
        ext_write_strobe = 4'b1111;
        ext_write_data   = wdata_q;
      end
    endcase
    if (!store_q) ext_write_strobe = 4'b0000;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: table of single transactions checked through a scoreboard queue,
// plus hand-written round-robin, timeout and mid-transaction reset sequences.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0, req_instruction = '0, req_store = '0, req_signed = '0;
  logic [3:0]  req_size = '0;
  logic [63:0] req_address = '0, req_store_data = '0;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_read_data = '0;

  logic [1:0]  a_req_ready, a_req_error, f_req_ready, f_req_error;
  logic [31:0] a_req_load_data, f_req_load_data, a_ext_address, f_ext_address;
  logic [31:0] a_ext_write_data, f_ext_write_data;
  logic [3:0]  a_ext_write_strobe, f_ext_write_strobe;
  logic        a_ext_valid, f_ext_valid, a_ext_instruction, f_ext_instruction;

  always #5 clk = ~clk;

  bus_arbiter #(.CHANNELS(2), .ROUND_ROBIN(1), .TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_instruction(req_instruction),
    .req_store(req_store), .req_signed(req_signed), .req_size(req_size),
    .req_address(req_address), .req_store_data(req_store_data), .req_ready(a_req_ready),
    .req_error(a_req_error), .req_load_data(a_req_load_data), .ext_valid(a_ext_valid),
    .ext_instruction(a_ext_instruction), .ext_ready(ext_ready), .ext_address(a_ext_address),
    .ext_write_data(a_ext_write_data), .ext_write_strobe(a_ext_write_strobe),
    .ext_read_data(ext_read_data)
  );

  bus_arbiter #(.CHANNELS(2), .ROUND_ROBIN(0), .TIMEOUT(0)) u_fix (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_instruction(req_instruction),
    .req_store(req_store), .req_signed(req_signed), .req_size(req_size),
    .req_address(req_address), .req_store_data(req_store_data), .req_ready(f_req_ready),
    .req_error(f_req_error), .req_load_data(f_req_load_data), .ext_valid(f_ext_valid),
    .ext_instruction(f_ext_instruction), .ext_ready(ext_ready), .ext_address(f_ext_address),
    .ext_write_data(f_ext_write_data), .ext_write_strobe(f_ext_write_strobe),
    .ext_read_data(ext_read_data)
  );

  typedef struct {
    int          ch;
    int          dly;
    logic        instr;
    logic        store;
    logic        sgn;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
    logic        e_err;
  } vec_t;

  vec_t tbl[12];
  vec_t sb_q[$];
  int   rr_q[$];
  int   fx_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = '0;
    ext_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    req_instruction[v.ch]           = v.instr;
    req_store[v.ch]                 = v.store;
    req_signed[v.ch]                = v.sgn;
    req_size[2*v.ch +: 2]           = v.size;
    req_address[32*v.ch +: 32]      = v.addr;
    req_store_data[32*v.ch +: 32]   = v.wdata;
    ext_read_data                   = v.rdata;
    req_valid[v.ch]                 = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t       e;
    int         n;
    logic       ev_seen;
    logic [1:0] exp_rdy;
    @(posedge clk); #1;
    drive(v);
    sb_q.push_back(v);
    n = 0;
    ev_seen = 1'b0;
    if (!v.e_err) begin
      do begin
        @(negedge clk);
        n++;
      end while (n < 8 && !a_ext_valid);
      check("bus_latency", 32'(n), 32'd2);
      check("ext_address", a_ext_address, v.e_addr);
      check("ext_strobe", 32'(a_ext_write_strobe), 32'(v.e_strb));
      check("ext_instruction", 32'(a_ext_instruction), 32'(v.instr));
      if (v.store) check("ext_write_data", a_ext_write_data, v.e_wdata);
      repeat (v.dly) @(negedge clk);
      check("ext_valid_held", 32'(a_ext_valid), 32'd1);
      ext_ready = 1'b1;
      @(posedge clk); #1 ext_ready = 1'b0;
      n = 0;
    end
    do begin
      @(negedge clk);
      n++;
      ev_seen = ev_seen | a_ext_valid;
    end while (n < 8 && a_req_ready == 2'b00);
    check("resp_latency", 32'(n), v.e_err ? 32'd2 : 32'd1);
    if (v.e_err) check("no_bus_cycle", 32'(ev_seen), 32'd0);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb_q.pop_front();
      exp_rdy = 2'b01 << e.ch;
      check("req_ready", 32'(a_req_ready), 32'(exp_rdy));
      check("req_error", 32'(a_req_error), e.e_err ? 32'(exp_rdy) : 32'd0);
      if (!e.store && !e.e_err) check("load_data", a_req_load_data, e.e_load);
    end
    req_valid[v.ch] = 1'b0;
    @(negedge clk);
    check("ready_pulse_end", 32'(a_req_ready), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic seen;
    vec_t v;

    tbl[0]  = '{0, 2, 1'b0, 1'b0, 1'b0, 2'd2, 32'h100,  32'h0,        32'hDEADBEEF,
                32'h100,  4'h0,    32'h0,        32'hDEADBEEF, 1'b0};
    tbl[1]  = '{0, 0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h103,  32'h0,        32'h80FFFFFF,
                32'h100,  4'h0,    32'h0,        32'hFFFFFF80, 1'b0};
    tbl[2]  = '{0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h103,  32'h0,        32'h80FFFFFF,
                32'h100,  4'h0,    32'h0,        32'h00000080, 1'b0};
    tbl[3]  = '{0, 1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h202,  32'h1234ABCD, 32'h0,
                32'h200,  4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
    tbl[4]  = '{0, 0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h001,  32'h000000A5, 32'h0,
                32'h000,  4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[5]  = '{1, 2, 1'b0, 1'b1, 1'b0, 2'd2, 32'h2000, 32'h12345678, 32'h0,
                32'h2000, 4'b1111, 32'h12345678, 32'h0,        1'b0};
    tbl[6]  = '{0, 3, 1'b1, 1'b0, 1'b1, 2'd1, 32'h302,  32'h0,        32'h80017FFF,
                32'h300,  4'h0,    32'h0,        32'hFFFF8001, 1'b0};
    tbl[7]  = '{1, 1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h300,  32'h0,        32'h80017FFF,
                32'h300,  4'h0,    32'h0,        32'h00007FFF, 1'b0};
    tbl[8]  = '{0, 0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h400,  32'h0,        32'hCAFEF00D,
                32'h400,  4'h0,    32'h0,        32'hCAFEF00D, 1'b0};
    tbl[9]  = '{0, 0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h102,  32'h0,        32'h00123456,
                32'h100,  4'h0,    32'h0,        32'h00000012, 1'b0};
    tbl[10] = '{0, 0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h101,  32'h0,        32'h0,
                32'h0,    4'h0,    32'h0,        32'h0,        1'b1};
    tbl[11] = '{1, 0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h203,  32'h5555,     32'h0,
                32'h0,    4'h0,    32'h0,        32'h0,        1'b1};

    do_reset();
    @(negedge clk);
    check("rst_ext_valid", 32'(a_ext_valid), 32'd0);
    check("rst_req_ready", 32'(a_req_ready), 32'd0);
    check("rst_req_error", 32'(a_req_error), 32'd0);
    check("rst_strobe", 32'(a_ext_write_strobe), 32'd0);
    check("rst_ext_address", a_ext_address, 32'd0);
    check("rst_load_data", a_req_load_data, 32'd0);

    for (int k = 0; k < 12; k++) run_vec(tbl[k]);

    // Both channels requesting continuously with the bus always ready.
    do_reset();
    rr_q = '{0, 1, 0, 1};
    fx_q = '{0, 0, 0, 0};
    @(posedge clk); #1;
    v = tbl[0];
    drive(v);
    v.ch = 1;
    v.addr = 32'h200;
    drive(v);
    ext_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (a_req_ready != 2'b00 && rr_q.size() > 0)
        check("rr_grant", 32'(a_req_ready), 32'(2'b01 << rr_q.pop_front()));
      if (f_req_ready != 2'b00 && fx_q.size() > 0)
        check("fixed_grant", 32'(f_req_ready), 32'(2'b01 << fx_q.pop_front()));
    end while (n < 30 && (rr_q.size() > 0 || fx_q.size() > 0));
    check("rr_grants_left", 32'(rr_q.size()), 32'd0);
    check("fixed_grants_left", 32'(fx_q.size()), 32'd0);

    // Bus never answers: four bus cycles, then an error completion.
    do_reset();
    @(posedge clk); #1;
    v = tbl[0];
    v.addr = 32'h500;
    drive(v);
    n = 0;
    cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (a_ext_valid) cnt++;
    end while (n < 20 && a_req_ready == 2'b00);
    check("timeout_bus_cycles", 32'(cnt), 32'd4);
    check("timeout_ready", 32'(a_req_ready), 32'd1);
    check("timeout_error", 32'(a_req_error), 32'd1);
    check("timeout_ext_valid", 32'(a_ext_valid), 32'd0);
    req_valid = '0;

    // Reset during the bus phase abandons the transaction silently.
    do_reset();
    @(posedge clk); #1;
    v.addr = 32'h600;
    drive(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 8 && !a_ext_valid);
    check("midrst_bus_entered", 32'(a_ext_valid), 32'd1);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("midrst_ext_valid", 32'(a_ext_valid), 32'd0);
    check("midrst_req_ready", 32'(a_req_ready), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | (a_req_ready != 2'b00) | a_ext_valid;
    end
    check("midrst_quiet", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
